// File: rtl/target_generator.sv
// target_generator: picks TARGETS distinct lit LEDs from a free-running LFSR,
// shows them for a bounded lifetime, blanks between rounds and flags expiry.
// Optional feature macro: TARGET_GEN_SPEEDUP_EN (hits shrink the lifetime).
module target_generator #(
    parameter int unsigned LIFETIME_CYCLES = 50_000_000,
    parameter int unsigned GAP_CYCLES      = 12_500_000,
    parameter int unsigned TARGETS         = 3,
    parameter logic [15:0] SEED            = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        hit,
    output logic [17:0] ledr,
    output logic        new_pattern,
    output logic        miss
);

    localparam int unsigned LED_W = 18;
    localparam int unsigned CNT_W = 3;
    localparam int unsigned TMR_W = 32;
    localparam int unsigned LFSR_W = 16;

    localparam logic [LFSR_W-1:0] LFSR_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [TMR_W-1:0]  LIFE_FULL = TMR_W'(LIFETIME_CYCLES);
    localparam logic [TMR_W-1:0]  GAP_LAST  = TMR_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_DONE  = CNT_W'(TARGETS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GEN,
        S_SHOW,
        S_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [LED_W-1:0]   shadow_q, shadow_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   count_inc;
    logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
    logic [LED_W-1:0]   idx_bit;
    logic [LED_W-1:0]   ledr_d;
    logic               new_pattern_d;
    logic               miss_d;
    logic [TMR_W-1:0]   life_q;
    logic               hit_accept;
    logic               expire;

    // Fibonacci LFSR (taps 16,14,13,11) and the candidate LED it points at
    always_comb begin
        lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        idx_bit   = LED_W'(1) << lfsr_q[4:0];
        count_inc = count_q + CNT_W'(1);
    end

    // Round-ending events while a pattern is on display; hit wins over expiry
    always_comb begin
        hit_accept = enable && (state_q == S_SHOW) && hit;
        expire     = enable && (state_q == S_SHOW) && !hit
                     && (timer_q == life_q - TMR_W'(1));
    end

`ifdef TARGET_GEN_SPEEDUP_EN
    localparam logic [TMR_W-1:0] LIFE_STEP  = TMR_W'(LIFETIME_CYCLES / 8);
    localparam logic [TMR_W-1:0] LIFE_FLOOR = TMR_W'(LIFETIME_CYCLES / 4);

    logic [TMR_W-1:0] life_d;

    // Lifetime shrinks per hit down to a floor; miss or a fresh game restores it
    always_comb begin
        life_d = life_q;
        if (enable && (state_q == S_IDLE)) begin
            life_d = LIFE_FULL;
        end else if (hit_accept) begin
            life_d = (life_q >= LIFE_FLOOR + LIFE_STEP) ? (life_q - LIFE_STEP) : LIFE_FLOOR;
        end else if (expire) begin
            life_d = LIFE_FULL;
        end
    end

    // Lifetime register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            life_q <= LIFE_FULL;
        end else begin
            life_q <= life_d;
        end
    end
`else
    assign life_q = LIFE_FULL;
`endif

    // Next-state and registered-output computation
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        shadow_d      = shadow_q;
        count_d       = count_q;
        ledr_d        = '0;
        new_pattern_d = 1'b0;
        miss_d        = 1'b0;

        if (!enable) begin
            state_d  = S_IDLE;
            timer_d  = '0;
            shadow_d = '0;
            count_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d  = S_GEN;
                    timer_d  = '0;
                    shadow_d = '0;
                    count_d  = '0;
                end
                S_GEN: begin
                    // idx >= 18 yields an empty one-hot and is skipped
                    if ((|idx_bit) && !(|(shadow_q & idx_bit))) begin
                        shadow_d = shadow_q | idx_bit;
                        count_d  = count_inc;
                        if (count_inc == CNT_DONE) begin
                            state_d       = S_SHOW;
                            ledr_d        = shadow_q | idx_bit;
                            new_pattern_d = 1'b1;
                            timer_d       = '0;
                        end
                    end
                end
                S_SHOW: begin
                    ledr_d  = ledr;
                    timer_d = timer_q + TMR_W'(1);
                    if (hit_accept) begin
                        state_d = S_GAP;
                        ledr_d  = '0;
                        timer_d = '0;
                    end else if (expire) begin
                        state_d = S_GAP;
                        ledr_d  = '0;
                        miss_d  = 1'b1;
                        timer_d = '0;
                    end
                end
                S_GAP: begin
                    if (timer_q == GAP_LAST) begin
                        state_d  = S_GEN;
                        timer_d  = '0;
                        shadow_d = '0;
                        count_d  = '0;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            shadow_q    <= '0;
            count_q     <= '0;
            lfsr_q      <= LFSR_INIT;
            ledr        <= '0;
            new_pattern <= 1'b0;
            miss        <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            shadow_q    <= shadow_d;
            count_q     <= count_d;
            lfsr_q      <= lfsr_d;
            ledr        <= ledr_d;
            new_pattern <= new_pattern_d;
            miss        <= miss_d;
        end
    end

endmodule
